// File: rtl/plab5_mcore_debug_mem_engine_pkg.sv
// Shared encodings for the debug memory engine: FSM states, debug
// instruction codes and memory request type codes.
package plab5_mcore_debug_mem_engine_pkg;

  localparam int unsigned ADDR_NBITS = 32;
  localparam int unsigned DATA_NBITS = 32;

  localparam logic DBG_COPY    = 1'b0;
  localparam logic DBG_EXTRACT = 1'b1;

  localparam logic MEMREQ_TYPE_READ  = 1'b0;
  localparam logic MEMREQ_TYPE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/plab5_mcore_debug_mem_engine_if.sv
// Memory network port: val/rdy request channel and val/rdy response channel.
// master = engine side, slave = memory side.
interface plab5_mcore_debug_mem_engine_if #(
  parameter int unsigned p_addr_nbits = 32,
  parameter int unsigned p_data_nbits = 32
);

  logic                    memreq_val;
  logic                    memreq_rdy;
  logic                    memreq_type;
  logic [p_addr_nbits-1:0] memreq_addr;
  logic [p_data_nbits-1:0] memreq_data;
  logic                    memreq_domain;
  logic                    memresp_val;
  logic                    memresp_rdy;
  logic [p_data_nbits-1:0] memresp_data;

  modport master (
    output memreq_val, memreq_type, memreq_addr, memreq_data, memreq_domain, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_data
  );

  modport slave (
    input  memreq_val, memreq_type, memreq_addr, memreq_data, memreq_domain, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_data
  );

endinterface

// File: rtl/plab5_mcore_debug_mem_engine_sec_check.sv
// Combinational domain check: an L-domain command touching the protected window is denied.
// Zero latency, no handshake; window bounds are unsigned and inclusive.
module plab5_mcore_debug_sec_check
  import plab5_mcore_debug_mem_engine_pkg::*;
#(
  parameter int unsigned             p_addr_nbits = ADDR_NBITS,
  parameter logic [p_addr_nbits-1:0] p_sec_base   = 32'h0000_8000,
  parameter logic [p_addr_nbits-1:0] p_sec_limit  = 32'h0000_FFFF
) (
  input  logic                    domain,
  input  logic                    inst,
  input  logic [p_addr_nbits-1:0] src,
  input  logic [p_addr_nbits-1:0] dest,
  output logic                    deny
);

  logic src_hit;
  logic dest_hit;

  assign src_hit  = (src  >= p_sec_base) && (src  <= p_sec_limit);
  assign dest_hit = (dest >= p_sec_base) && (dest <= p_sec_limit);

  // Only a copy ever touches dest, so extract ignores it.
  assign deny = !domain && (src_hit || ((inst == DBG_COPY) && dest_hit));

endmodule

// File: rtl/plab5_mcore_debug_mem_engine.sv
// Runs one copy/extract debug command against the memory port; ack T+3 extract, T+5 copy, T+1 denied.
// Holds memreq stable until memreq_rdy; memresp_rdy is always high so stale responses drain harmlessly.
module plab5_mcore_debug_mem_engine
  import plab5_mcore_debug_mem_engine_pkg::*;
#(
  parameter int unsigned             p_addr_nbits = ADDR_NBITS,
  parameter int unsigned             p_data_nbits = DATA_NBITS,
  parameter logic [p_addr_nbits-1:0] p_sec_base   = 32'h0000_8000,
  parameter logic [p_addr_nbits-1:0] p_sec_limit  = 32'h0000_FFFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    inst,
  input  logic [p_addr_nbits-1:0] src_addr,
  input  logic [p_addr_nbits-1:0] dest_addr,
  input  logic                    domain,
  output logic                    ack,
  output logic                    resp_domain,
  output logic [p_data_nbits-1:0] read_data,
  output logic                    db_resp_domain,
  output logic                    err,
  plab5_mcore_debug_mem_engine_if.master mem
);

  state_t                  state;
  state_t                  state_next;
  logic                    accept;
  logic                    deny;
  logic                    cmd_inst;
  logic                    cmd_domain;
  logic [p_addr_nbits-1:0] cmd_src;
  logic [p_addr_nbits-1:0] cmd_dest;
  logic [p_data_nbits-1:0] data_reg;
  logic                    err_reg;

  plab5_mcore_debug_sec_check #(
    .p_addr_nbits (p_addr_nbits),
    .p_sec_base   (p_sec_base),
    .p_sec_limit  (p_sec_limit)
  ) sec_check (
    .domain (domain),
    .inst   (inst),
    .src    (src_addr),
    .dest   (dest_addr),
    .deny   (deny)
  );

  assign accept = start && (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_inst   <= DBG_COPY;
      cmd_domain <= 1'b0;
      cmd_src    <= '0;
      cmd_dest   <= '0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      cmd_inst   <= inst;
      cmd_domain <= domain;
      cmd_src    <= src_addr;
      cmd_dest   <= dest_addr;
      err_reg    <= deny;
    end
  end

  // Cleared on every accepted command so a denied command reports zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   data_reg <= '0;
    else if (accept)                              data_reg <= '0;
    else if ((state == ST_RD_WAIT) && mem.memresp_val) data_reg <= mem.memresp_data;
  end

  always_comb begin
    state_next        = state;
    ack               = 1'b0;
    mem.memreq_val    = 1'b0;
    mem.memreq_type   = MEMREQ_TYPE_READ;
    mem.memreq_addr   = cmd_src;
    mem.memreq_data   = data_reg;
    mem.memreq_domain = cmd_domain;
    mem.memresp_rdy   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start) state_next = deny ? ST_DONE : ST_RD_REQ;
      end
      ST_RD_REQ: begin
        mem.memreq_val = 1'b1;
        if (mem.memreq_rdy) state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem.memresp_val) state_next = (cmd_inst == DBG_COPY) ? ST_WR_REQ : ST_DONE;
      end
      ST_WR_REQ: begin
        mem.memreq_val  = 1'b1;
        mem.memreq_type = MEMREQ_TYPE_WRITE;
        mem.memreq_addr = cmd_dest;
        if (mem.memreq_rdy) state_next = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mem.memresp_val) state_next = ST_DONE;
      end
      ST_DONE: begin
        ack        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign resp_domain    = cmd_domain;
  assign db_resp_domain = cmd_domain;
  assign read_data      = data_reg;
  assign err            = err_reg;

endmodule
